// File: rtl/afu_mmio_responder.sv
// afu_mmio_responder: AFU-side responder for host MMIO requests from the PSL.
// A request is captured in IDLE, decoded in DECODE (read mux registered, writes
// applied), and acknowledged for one cycle in RESP, giving an ack two cycles
// after mmio_val.
// Bit numbering: the PSL labels address bits [0:23] and data bits [0:63]
// MSB-first. Here vectors are [W-1:0], so PSL address bit 23 (the 32-bit half
// select) is mmio_ad[0], and PSL data bits [0:31] are mmio_rdata[63:32].
// Optional feature macro: MMIO_PARITY_EN adds a registered odd-parity bit on
// mmio_rdata. When it is undefined, mmio_rdata_par is tied to 0.
module afu_mmio_responder #(
  parameter int MMIO_ADDR_W = 24,
  parameter int DATA_W      = 64,
  parameter int ERROR_W     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mmio_val,
  input  logic                   mmio_cfg,
  input  logic                   mmio_rnw,
  input  logic                   mmio_dw,
  input  logic [MMIO_ADDR_W-1:0] mmio_ad,
  input  logic [DATA_W-1:0]      mmio_wdata,
  output logic                   mmio_ack,
  output logic [DATA_W-1:0]      mmio_rdata,
  output logic                   mmio_rdata_par,
  input  logic [DATA_W-1:0]      afu_status,
  input  logic [DATA_W-1:0]      cu_status,
  input  logic [DATA_W-1:0]      cu_return,
  input  logic                   cu_return_done_val,
  input  logic [DATA_W-1:0]      cu_return_done,
  input  logic [ERROR_W-1:0]     error_in,
  input  logic [DATA_W-1:0]      done_count,
  input  logic [DATA_W-1:0]      read_byte_count,
  input  logic [DATA_W-1:0]      write_byte_count,
  input  logic [DATA_W-1:0]      cycle_count,
  output logic [DATA_W-1:0]      afu_configure,
  output logic [DATA_W-1:0]      afu_configure_2,
  output logic [DATA_W-1:0]      cu_configure,
  output logic [DATA_W-1:0]      cu_configure_2,
  output logic                   cu_return_done_ack
);

  localparam int HALF = DATA_W / 2;

  // Word addresses (global MMIO byte address >> 2); 64-bit registers sit on even words.
  localparam logic [MMIO_ADDR_W-1:0] AFU_STATUS_A         = MMIO_ADDR_W'(24'hFFFFFE);
  localparam logic [MMIO_ADDR_W-1:0] AFU_CONFIGURE_A      = MMIO_ADDR_W'(24'hFFFFFC);
  localparam logic [MMIO_ADDR_W-1:0] AFU_CONFIGURE_2_A    = MMIO_ADDR_W'(24'hFFFFFA);
  localparam logic [MMIO_ADDR_W-1:0] CU_STATUS_A          = MMIO_ADDR_W'(24'hFFFFF8);
  localparam logic [MMIO_ADDR_W-1:0] CU_CONFIGURE_A       = MMIO_ADDR_W'(24'hFFFFF6);
  localparam logic [MMIO_ADDR_W-1:0] CU_CONFIGURE_2_A     = MMIO_ADDR_W'(24'hFFFFF4);
  localparam logic [MMIO_ADDR_W-1:0] CU_RETURN_A          = MMIO_ADDR_W'(24'hFFFFF2);
  localparam logic [MMIO_ADDR_W-1:0] CU_RETURN_DONE_A     = MMIO_ADDR_W'(24'hFFFFF0);
  localparam logic [MMIO_ADDR_W-1:0] CU_RETURN_DONE_ACK_A = MMIO_ADDR_W'(24'hFFFFEE);
  localparam logic [MMIO_ADDR_W-1:0] ERROR_REG_A          = MMIO_ADDR_W'(24'hFFFFE2);
  localparam logic [MMIO_ADDR_W-1:0] ERROR_REG_ACK_A      = MMIO_ADDR_W'(24'hFFFFE0);
  localparam logic [MMIO_ADDR_W-1:0] DONE_COUNT_A         = MMIO_ADDR_W'(24'hFFFFDE);
  localparam logic [MMIO_ADDR_W-1:0] READ_BYTE_COUNT_A    = MMIO_ADDR_W'(24'hFFFFDC);
  localparam logic [MMIO_ADDR_W-1:0] WRITE_BYTE_COUNT_A   = MMIO_ADDR_W'(24'hFFFFDA);
  localparam logic [MMIO_ADDR_W-1:0] CYCLE_COUNT_A        = MMIO_ADDR_W'(24'hFFFFD8);

  typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

  state_t                 state_q;
  logic                   ack_q;
  logic                   cdack_q;
  logic [DATA_W-1:0]      rdata_q;
`ifdef MMIO_PARITY_EN
  logic                   par_q;
`endif

  logic                   rnw_q, dw_q, cfg_q;
  logic [MMIO_ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0]      wdata_q;

  logic [DATA_W-1:0]      afu_cfg_q, afu_cfg_d, afu_cfg2_q, afu_cfg2_d;
  logic [DATA_W-1:0]      cu_cfg_q, cu_cfg_d, cu_cfg2_q, cu_cfg2_d;
  logic [DATA_W-1:0]      rdone_q, rdone_d;
  logic [ERROR_W-1:0]     err_q, err_d;

  logic [MMIO_ADDR_W-1:0] base;
  logic                   odd, legal, wr_en, done_ack_hit;
  logic [DATA_W-1:0]      wmask, wr_bits, full, rd_val;

  // Address decode and read mux from the captured request.
  always_comb begin
    base  = {ad_q[MMIO_ADDR_W-1:1], 1'b0};
    odd   = ad_q[0];
    // Config-space accesses and 64-bit accesses to an odd word are acked but inert.
    legal = !cfg_q && !(dw_q && odd);
    wr_en = (state_q == DECODE) && legal && !rnw_q;
    if (dw_q)     wmask = '1;
    else if (odd) wmask = {{HALF{1'b0}}, {HALF{1'b1}}};
    else          wmask = {{HALF{1'b1}}, {HALF{1'b0}}};
    wr_bits = wdata_q & wmask;
    case (base)
      AFU_STATUS_A:       full = afu_status;
      AFU_CONFIGURE_A:    full = afu_cfg_q;
      AFU_CONFIGURE_2_A:  full = afu_cfg2_q;
      CU_STATUS_A:        full = cu_status;
      CU_CONFIGURE_A:     full = cu_cfg_q;
      CU_CONFIGURE_2_A:   full = cu_cfg2_q;
      CU_RETURN_A:        full = cu_return;
      CU_RETURN_DONE_A:   full = rdone_q;
      ERROR_REG_A:        full = DATA_W'(err_q);
      DONE_COUNT_A:       full = done_count;
      READ_BYTE_COUNT_A:  full = read_byte_count;
      WRITE_BYTE_COUNT_A: full = write_byte_count;
      CYCLE_COUNT_A:      full = cycle_count;
      default:            full = '0;
    endcase
    // A 32-bit read replicates the selected half into both halves of the bus.
    if (!legal)     rd_val = '0;
    else if (dw_q)  rd_val = full;
    else if (odd)   rd_val = {2{full[HALF-1:0]}};
    else            rd_val = {2{full[DATA_W-1:HALF]}};
  end

  // Register writes, latch loads and sticky error accumulation.
  always_comb begin
    afu_cfg_d    = afu_cfg_q;
    afu_cfg2_d   = afu_cfg2_q;
    cu_cfg_d     = cu_cfg_q;
    cu_cfg2_d    = cu_cfg2_q;
    rdone_d      = rdone_q;
    err_d        = err_q;
    done_ack_hit = 1'b0;
    if (wr_en) begin
      case (base)
        AFU_CONFIGURE_A:      afu_cfg_d  = (afu_cfg_q  & ~wmask) | wr_bits;
        AFU_CONFIGURE_2_A:    afu_cfg2_d = (afu_cfg2_q & ~wmask) | wr_bits;
        CU_CONFIGURE_A:       cu_cfg_d   = (cu_cfg_q   & ~wmask) | wr_bits;
        CU_CONFIGURE_2_A:     cu_cfg2_d  = (cu_cfg2_q  & ~wmask) | wr_bits;
        CU_RETURN_DONE_ACK_A: begin
          rdone_d      = '0;
          done_ack_hit = 1'b1;
        end
        ERROR_REG_ACK_A:      err_d = err_q & ~ERROR_W'(wr_bits);
        default:              ;
      endcase
    end
    // New events override a same-cycle clear.
    err_d = err_d | error_in;
    if (cu_return_done_val) rdone_d = cu_return_done;
  end

  // Request FSM with registered ack, read data, parity and done-ack pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cdack_q <= 1'b0;
      rdata_q <= '0;
`ifdef MMIO_PARITY_EN
      par_q   <= 1'b1;
`endif
    end else begin
      ack_q   <= 1'b0;
      cdack_q <= 1'b0;
      case (state_q)
        IDLE:   if (mmio_val) state_q <= DECODE;
        DECODE: begin
          state_q <= RESP;
          ack_q   <= 1'b1;
          cdack_q <= done_ack_hit;
          if (rnw_q) begin
            rdata_q <= rd_val;
`ifdef MMIO_PARITY_EN
            par_q   <= ~^rd_val;
`endif
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request capture; only accepted while idle, so extra pulses are dropped.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && mmio_val) begin
      rnw_q   <= mmio_rnw;
      dw_q    <= mmio_dw;
      cfg_q   <= mmio_cfg;
      ad_q    <= mmio_ad;
      wdata_q <= mmio_wdata;
    end
  end

  // Configure registers, CU_RETURN_DONE latch and sticky error vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      afu_cfg_q  <= '0;
      afu_cfg2_q <= '0;
      cu_cfg_q   <= '0;
      cu_cfg2_q  <= '0;
      rdone_q    <= '0;
      err_q      <= '0;
    end else begin
      afu_cfg_q  <= afu_cfg_d;
      afu_cfg2_q <= afu_cfg2_d;
      cu_cfg_q   <= cu_cfg_d;
      cu_cfg2_q  <= cu_cfg2_d;
      rdone_q    <= rdone_d;
      err_q      <= err_d;
    end
  end

  assign mmio_ack           = ack_q;
  assign mmio_rdata         = rdata_q;
  assign cu_return_done_ack = cdack_q;
  assign afu_configure      = afu_cfg_q;
  assign afu_configure_2    = afu_cfg2_q;
  assign cu_configure       = cu_cfg_q;
  assign cu_configure_2     = cu_cfg2_q;
`ifdef MMIO_PARITY_EN
  assign mmio_rdata_par     = par_q;
`else
  assign mmio_rdata_par     = 1'b0;
`endif

endmodule

// File: tb/tb_afu_mmio_responder.sv
// Bench for afu_mmio_responder: directed register-map scenarios followed by
// random MMIO traffic, checked each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_afu_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        mmio_val, mmio_cfg, mmio_rnw, mmio_dw;
  logic [23:0] mmio_ad;
  logic [63:0] mmio_wdata;
  logic        mmio_ack;
  logic [63:0] mmio_rdata;
  logic        mmio_rdata_par;
  logic [63:0] afu_status, cu_status, cu_return, cu_return_done, error_in;
  logic [63:0] done_count, read_byte_count, write_byte_count, cycle_count;
  logic        cu_return_done_val;
  logic [63:0] afu_configure, afu_configure_2, cu_configure, cu_configure_2;
  logic        cu_return_done_ack;

  always #5 clock = ~clock;

  // Live inputs: directed values (d_*) or per-cycle random values (n_*).
  bit          noise_en;
  logic [63:0] d_live [9];
  logic [63:0] n_live [9];
  logic        d_crdv, n_crdv;
  assign afu_status         = noise_en ? n_live[0] : d_live[0];
  assign cu_status          = noise_en ? n_live[1] : d_live[1];
  assign cu_return          = noise_en ? n_live[2] : d_live[2];
  assign cu_return_done     = noise_en ? n_live[3] : d_live[3];
  assign error_in           = noise_en ? n_live[4] : d_live[4];
  assign done_count         = noise_en ? n_live[5] : d_live[5];
  assign read_byte_count    = noise_en ? n_live[6] : d_live[6];
  assign write_byte_count   = noise_en ? n_live[7] : d_live[7];
  assign cycle_count        = noise_en ? n_live[8] : d_live[8];
  assign cu_return_done_val = noise_en ? n_crdv : d_crdv;

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 9; i++) n_live[i] = {$urandom, $urandom};
    n_live[4] = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
    n_crdv    = ($urandom_range(0, 7) == 0);
  end

  afu_mmio_responder dut (
    .clock(clock), .reset(reset),
    .mmio_val(mmio_val), .mmio_cfg(mmio_cfg), .mmio_rnw(mmio_rnw), .mmio_dw(mmio_dw),
    .mmio_ad(mmio_ad), .mmio_wdata(mmio_wdata),
    .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata), .mmio_rdata_par(mmio_rdata_par),
    .afu_status(afu_status), .cu_status(cu_status), .cu_return(cu_return),
    .cu_return_done_val(cu_return_done_val), .cu_return_done(cu_return_done),
    .error_in(error_in), .done_count(done_count), .read_byte_count(read_byte_count),
    .write_byte_count(write_byte_count), .cycle_count(cycle_count),
    .afu_configure(afu_configure), .afu_configure_2(afu_configure_2),
    .cu_configure(cu_configure), .cu_configure_2(cu_configure_2),
    .cu_return_done_ack(cu_return_done_ack)
  );

  // ---------------- transaction-level reference model ----------------
  int          cyc, next_free, p_cyc;
  bit          pend;
  logic        p_rnw, p_dw, p_cfg;
  logic [23:0] p_ad;
  logic [63:0] p_wd;
  logic [63:0] m_cfg [4];  // afu_configure, afu_configure_2, cu_configure, cu_configure_2
  logic [63:0] m_err, m_done, e_rdata;
  bit          e_ack, e_cdack, e_hold;
  logic [23:0] mv_base;
  logic [63:0] mv_full, mv_mask, mv_clr;
  bit          mv_ok, mv_clr_done;

  function automatic logic [63:0] reg_val(input logic [23:0] w);
    case (w)
      24'hFFFFFE: return afu_status;
      24'hFFFFFC: return m_cfg[0];
      24'hFFFFFA: return m_cfg[1];
      24'hFFFFF8: return cu_status;
      24'hFFFFF6: return m_cfg[2];
      24'hFFFFF4: return m_cfg[3];
      24'hFFFFF2: return cu_return;
      24'hFFFFF0: return m_done;
      24'hFFFFE2: return m_err;
      24'hFFFFDE: return done_count;
      24'hFFFFDC: return read_byte_count;
      24'hFFFFDA: return write_byte_count;
      24'hFFFFD8: return cycle_count;
      default:    return 64'h0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend = 0; next_free = 0;
      for (int i = 0; i < 4; i++) m_cfg[i] = 64'h0;
      m_err = 0; m_done = 0; e_ack = 0; e_cdack = 0; e_rdata = 0; e_hold = 1;
    end else begin
      cyc++;
      e_ack = 0; e_cdack = 0; mv_clr = 0; mv_clr_done = 0;
      // A request accepted at edge c resolves at edge c+1 and is acked until edge c+2.
      if (pend && cyc == p_cyc + 1) begin
        pend    = 0;
        e_ack   = 1;
        mv_base = {p_ad[23:1], 1'b0};
        mv_ok   = !p_cfg && !(p_dw && p_ad[0]);
        mv_mask = p_dw ? 64'hFFFF_FFFF_FFFF_FFFF :
                  (p_ad[0] ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_0000_0000);
        if (p_rnw) begin
          mv_full = mv_ok ? reg_val(mv_base) : 64'h0;
          if (!p_dw) mv_full = p_ad[0] ? {mv_full[31:0], mv_full[31:0]} : {mv_full[63:32], mv_full[63:32]};
          e_rdata = mv_full;
          e_hold  = 1;
        end else begin
          e_hold = 0;
          if (mv_ok) begin
            case (mv_base)
              24'hFFFFFC: m_cfg[0] = (m_cfg[0] & ~mv_mask) | (p_wd & mv_mask);
              24'hFFFFFA: m_cfg[1] = (m_cfg[1] & ~mv_mask) | (p_wd & mv_mask);
              24'hFFFFF6: m_cfg[2] = (m_cfg[2] & ~mv_mask) | (p_wd & mv_mask);
              24'hFFFFF4: m_cfg[3] = (m_cfg[3] & ~mv_mask) | (p_wd & mv_mask);
              24'hFFFFEE: begin mv_clr_done = 1; e_cdack = 1; end
              24'hFFFFE0: mv_clr = p_wd & mv_mask;
              default: ;
            endcase
          end
        end
      end
      if (mmio_val && cyc >= next_free) begin
        pend = 1; p_cyc = cyc; next_free = cyc + 3;
        p_rnw = mmio_rnw; p_dw = mmio_dw; p_cfg = mmio_cfg; p_ad = mmio_ad; p_wd = mmio_wdata;
      end
      m_err = (m_err & ~mv_clr) | error_in;
      if (mv_clr_done) m_done = 0;
      if (cu_return_done_val) m_done = cu_return_done;
    end
  end

  // ---------------- checking ----------------
  int checks, errors;

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One MMIO request; the ack must be absent one cycle later and present two cycles later.
  task automatic txn(input bit rnw, input bit dw, input bit cfg, input logic [23:0] ad,
                     input logic [63:0] wd, input bit extra, output logic [63:0] rd);
    @(posedge clock); #1;
    mmio_val = 1; mmio_rnw = rnw; mmio_dw = dw; mmio_cfg = cfg; mmio_ad = ad; mmio_wdata = wd;
    @(posedge clock); #1;
    mmio_val = extra;
    if (extra) begin
      mmio_rnw = 1'($urandom); mmio_dw = 1'($urandom); mmio_ad = 24'($urandom);
      mmio_wdata = {$urandom, $urandom};
    end
    @(negedge clock);
    chk1("ack_before_T2", mmio_ack, 1'b0);
    @(posedge clock); #1;
    mmio_val = 0;
    @(negedge clock);
    chk1("ack_at_T2", mmio_ack, 1'b1);
    rd = mmio_rdata;
  endtask

  function automatic logic [23:0] pick_addr(input int i);
    case (i)
      0: return 24'hFFFFFE;  1: return 24'hFFFFFC;  2: return 24'hFFFFFA;
      3: return 24'hFFFFF8;  4: return 24'hFFFFF6;  5: return 24'hFFFFF4;
      6: return 24'hFFFFF2;  7: return 24'hFFFFF0;  8: return 24'hFFFFEE;
      9: return 24'hFFFFE2; 10: return 24'hFFFFE0; 11: return 24'hFFFFDE;
     12: return 24'hFFFFDC; 13: return 24'hFFFFDA; 14: return 24'hFFFFD8;
      default: return 24'h000010;
    endcase
  endfunction

  initial begin
    logic [63:0] rd;
    logic [31:0] w32;
    int          ackcnt;
    bit          r_dw;
    checks = 0; errors = 0;
    reset = 1; noise_en = 0; d_crdv = 0;
    mmio_val = 0; mmio_cfg = 0; mmio_rnw = 0; mmio_dw = 0; mmio_ad = 0; mmio_wdata = 0;
    for (int i = 0; i < 9; i++) d_live[i] = 64'h0;
    fork
      begin : monitor
        repeat (2) @(posedge clock);
        forever begin
          @(negedge clock);
          chk1("ack", mmio_ack, e_ack);
          chk1("cu_return_done_ack", cu_return_done_ack, e_cdack);
          chk64("afu_configure", afu_configure, m_cfg[0]);
          chk64("afu_configure_2", afu_configure_2, m_cfg[1]);
          chk64("cu_configure", cu_configure, m_cfg[2]);
          chk64("cu_configure_2", cu_configure_2, m_cfg[3]);
          if (e_hold) begin
            chk64("rdata", mmio_rdata, e_rdata);
`ifdef MMIO_PARITY_EN
            chk1("rdata_par", mmio_rdata_par, ~^e_rdata);
`endif
          end
`ifndef MMIO_PARITY_EN
          chk1("rdata_par_tied", mmio_rdata_par, 1'b0);
`endif
        end
      end
      begin : stimulus
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk1("reset_ack", mmio_ack, 1'b0);
        chk64("reset_rdata", mmio_rdata, 64'h0);
        chk64("reset_afu_configure", afu_configure, 64'h0);
        chk1("reset_done_ack", cu_return_done_ack, 1'b0);
`ifdef MMIO_PARITY_EN
        chk1("reset_par", mmio_rdata_par, 1'b1);
`endif
        @(posedge clock); #1 reset = 0;

        // 64-bit configure write and readback
        txn(0, 1, 0, 24'hFFFFFC, 64'h0123_4567_89AB_CDEF, 0, rd);
        txn(1, 1, 0, 24'hFFFFFC, 64'h0, 0, rd);
        chk64("afu_cfg_readback", rd, 64'h0123_4567_89AB_CDEF);
        chk64("afu_configure_out", afu_configure, 64'h0123_4567_89AB_CDEF);

        // 32-bit reads replicate the selected half
        d_live[5] = 64'hAAAA_BBBB_CCCC_DDDD;
        txn(1, 0, 0, 24'hFFFFDE, 64'h0, 0, rd);
        chk64("done_count_hi32", rd, 64'hAAAABBBB_AAAABBBB);
        txn(1, 0, 0, 24'hFFFFDF, 64'h0, 0, rd);
        chk64("done_count_lo32", rd, 64'hCCCCDDDD_CCCCDDDD);

        // sticky errors with write-1-to-clear; set beats clear
        @(posedge clock); #1 d_live[4] = 64'h5;
        @(posedge clock); #1 d_live[4] = 64'h1;
        txn(0, 1, 0, 24'hFFFFE0, 64'h1, 0, rd);
        @(posedge clock); #1 d_live[4] = 64'h0;
        txn(1, 1, 0, 24'hFFFFE2, 64'h0, 0, rd);
        chk64("error_set_wins", rd, 64'h5);
        txn(0, 1, 0, 24'hFFFFE0, 64'h1, 0, rd);
        txn(1, 1, 0, 24'hFFFFE2, 64'h0, 0, rd);
        chk64("error_cleared", rd, 64'h4);

        // CU_RETURN_DONE latch and acknowledge pulse
        @(posedge clock); #1 d_live[3] = 64'h42; d_crdv = 1;
        @(posedge clock); #1 d_crdv = 0;
        txn(1, 1, 0, 24'hFFFFF0, 64'h0, 0, rd);
        chk64("return_done_latched", rd, 64'h42);
        txn(0, 1, 0, 24'hFFFFEE, 64'h0, 0, rd);
        chk1("done_ack_pulse", cu_return_done_ack, 1'b1);
        @(negedge clock);
        chk1("done_ack_one_cycle", cu_return_done_ack, 1'b0);
        txn(1, 1, 0, 24'hFFFFF0, 64'h0, 0, rd);
        chk64("return_done_cleared", rd, 64'h0);

        // unmapped, config-space and a second mmio_val during DECODE
        d_live[0] = 64'hDEAD_BEEF_1234_5678;
        txn(1, 1, 0, 24'h000010, 64'h0, 0, rd);
        chk64("unmapped_read", rd, 64'h0);
        txn(1, 1, 1, 24'hFFFFFE, 64'h0, 0, rd);
        chk64("cfg_space_read", rd, 64'h0);
        txn(1, 1, 0, 24'hFFFFFE, 64'h0, 1, rd);
        chk64("afu_status_read", rd, 64'hDEAD_BEEF_1234_5678);
        ackcnt = 0;
        repeat (6) begin @(negedge clock); if (mmio_ack) ackcnt++; end
        chk64("no_extra_ack", 64'(ackcnt), 64'h0);

        // reset while the request sits in DECODE
        txn(0, 1, 0, 24'hFFFFF6, 64'h77, 0, rd);
        @(posedge clock); #1;
        mmio_val = 1; mmio_rnw = 1; mmio_dw = 1; mmio_cfg = 0; mmio_ad = 24'hFFFFF6;
        @(posedge clock); #1 mmio_val = 0;
        #2 reset = 1;
        ackcnt = 0;
        repeat (4) begin @(negedge clock); if (mmio_ack) ackcnt++; end
        chk64("reset_drop_no_ack", 64'(ackcnt), 64'h0);
        chk64("reset_cu_configure", cu_configure, 64'h0);
        chk64("reset_mid_rdata", mmio_rdata, 64'h0);
        @(posedge clock); #1 reset = 0;

        // parity of reads returning 1 and 0
        txn(0, 1, 0, 24'hFFFFF6, 64'h1, 0, rd);
        txn(1, 1, 0, 24'hFFFFF6, 64'h0, 0, rd);
        chk64("read_one", rd, 64'h1);
`ifdef MMIO_PARITY_EN
        chk1("par_of_one", mmio_rdata_par, 1'b0);
`endif
        txn(1, 1, 0, 24'h000010, 64'h0, 0, rd);
        chk64("read_zero", rd, 64'h0);
`ifdef MMIO_PARITY_EN
        chk1("par_of_zero", mmio_rdata_par, 1'b1);
`endif

        // random traffic
        noise_en = 1;
        for (int k = 0; k < 300; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clock);
          r_dw = 1'($urandom);
          w32  = $urandom;
          txn(1'($urandom),
              r_dw,
              $urandom_range(0, 15) == 0,
              ($urandom_range(0, 7) == 0) ? 24'($urandom) : (pick_addr($urandom_range(0, 14)) | 24'($urandom_range(0, 1))),
              r_dw ? {$urandom, $urandom} : {w32, w32},
              $urandom_range(0, 7) == 0,
              rd);
        end
        repeat (4) @(posedge clock);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afu_mmio_responder.md
Name: afu_mmio_responder

Overview:
- AFU-side responder for host MMIO transactions issued over the PSL MMIO interface.
- Decodes 24-bit word addresses: the global MMIO map addresses shifted right by 2, e.g. AFU_STATUS = 0xFFFFFE.
- Returns status and stats counters, holds configure registers, and runs the CU_RETURN_DONE and ERROR_REG acknowledge handshakes toward the compute unit.
- Sits between the PSL MMIO port and afu_control/cu_control.

Parameters:
- MMIO_ADDR_W, 24, word-address width.
- DATA_W, 64, MMIO data width.
- ERROR_W, 64, width of sticky error vector.

Ports:
- clock  in  1  AFU clock
- reset  in  1  asynchronous, active-high reset
- mmio_val  in  1  request valid, single-cycle pulse
- mmio_cfg  in  1  config-space access
- mmio_rnw  in  1  1 = read, 0 = write
- mmio_dw  in  1  1 = 64-bit access, 0 = 32-bit access
- mmio_ad  in  24  word address [0:23]
- mmio_wdata  in  64  write data [0:63]
- mmio_ack  out  1  response pulse
- mmio_rdata  out  64  read data, valid with mmio_ack
- mmio_rdata_par  out  1  odd parity of mmio_rdata (feature only)
- afu_status  in  64  live AFU status
- cu_status  in  64  live CU status
- cu_return  in  64  running CU counter
- cu_return_done_val  in  1  CU final-result strobe
- cu_return_done  in  64  CU final result
- error_in  in  64  error pulses, one bit per source
- done_count, read_byte_count, write_byte_count, cycle_count  in  64 each  stats
- afu_configure, afu_configure_2, cu_configure, cu_configure_2  out  64 each  config registers
- cu_return_done_ack  out  1  one-cycle pulse to CU

Behaviour:
- FSM states: IDLE, DECODE, RESP.
  - IDLE + mmio_val → DECODE; address, rnw, dw and wdata are captured.
  - DECODE → RESP; read mux is registered, write is applied.
  - RESP: mmio_ack = 1 for exactly one cycle → IDLE.
- Latency: mmio_val at cycle T → mmio_ack at T+2. Back-to-back requests are accepted from T+3.
- mmio_val outside IDLE: ignored, never acked (PSL guarantees one outstanding request).
- mmio_cfg = 1:
  - Read returns 0.
  - Write is ignored.
  - Acked with the normal latency.
- 64-bit access (mmio_dw = 1): mmio_ad[23] must be 0. If mmio_ad[23] = 1, the read returns 0, the write is ignored, and the request is still acked.
- 32-bit read: the register half selected by mmio_ad[23] (0 → bits [0:31], 1 → bits [32:63]) is replicated into both halves of mmio_rdata.
- 32-bit write: updates only the selected half of the register.
- Read map: AFU_STATUS, CU_STATUS, CU_RETURN, CU_RETURN_DONE, ERROR_REG, DONE_COUNT_REG, READ_BYTE_COUNT_REG, WRITE_BYTE_COUNT_REG, CYCLE_COUNT_REG, and the four configure registers (readback).
- Unmapped read returns 0. Unmapped write is ignored. Both are acked.
- CU_RETURN_DONE latch:
  - Loaded on cu_return_done_val.
  - Write of any data to CU_RETURN_DONE_ACK clears the latch to 0 and pulses cu_return_done_ack in the RESP cycle.
  - cu_return_done_val in the same cycle as the clear: the load wins.
- ERROR_REG:
  - Sticky set: err <= err | error_in.
  - Write to ERROR_REG_ACK clears the bits written as 1 (write-1-to-clear).
  - Same-cycle set and clear on a bit: set wins.
- mmio_rdata holds its value after ack until the next response.
- Reset:
  - mmio_ack = 0, mmio_rdata = 0, mmio_rdata_par = 1 (odd parity of zero).
  - All configure registers = 0, latches = 0, cu_return_done_ack = 0.
  - FSM → IDLE.
  - Reset mid-transaction drops the request with no ack.

Optional Feature:
- Macro: MMIO_PARITY_EN.
- Defined: mmio_rdata_par is driven registered with mmio_rdata, such that ^{mmio_rdata, mmio_rdata_par} = 1 (odd parity).
- Undefined: mmio_rdata_par is tied to 0 and no parity logic is synthesised.

Test Plan:
- Reset, then 64-bit write 0x0123_4567_89AB_CDEF to AFU_CONFIGURE (0xFFFFFC), then read it back → ack exactly at T+2 for each transaction; data = 0x0123_4567_89AB_CDEF; afu_configure output matches.
- 32-bit read of DONE_COUNT_REG (0xFFFFDE) then 0xFFFFDF with done_count = 0xAAAA_BBBB_CCCC_DDDD → returns 0xAAAABBBB_AAAABBBB, then 0xCCCCDDDD_CCCCDDDD.
- error_in pulses 0x5, then write 0x1 to ERROR_REG_ACK (0xFFFFE0) while error_in = 0x1 in the clear cycle → ERROR_REG reads 0x5; a second clear with error_in idle → reads 0x4.
- cu_return_done_val with 0x42, read CU_RETURN_DONE → 0x42; write CU_RETURN_DONE_ACK → one-cycle cu_return_done_ack pulse; reread → 0.
- Read unmapped 0x000010, and a config-space read → both acked with 0; second mmio_val while in DECODE → no extra ack.
- Assert reset in DECODE → no ack, all outputs 0; with MMIO_PARITY_EN, read 0x1 → mmio_rdata_par = 0; read 0x0 → mmio_rdata_par = 1.
